// File: rtl/spi_controller.sv
// SPI mode-0 master: shifts a width-bit word out on mosi (MSB first) while capturing miso.
// Start/busy/done handshake on the software side; every pin output is registered.
module spi_controller #(
   parameter int unsigned width  = 8,
   parameter int unsigned clkdiv = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [width-1:0] txData,
   output logic [width-1:0] rxData,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int unsigned PW = $clog2(2 * clkdiv);
   localparam int unsigned BW = $clog2(width);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCLK_LOW,
      SCLK_HIGH,
      HOLD
   } state_t;

   state_t             state, state_d;
   logic [PW-1:0]      phase, phase_d;
   logic [BW-1:0]      bit_cnt, bit_cnt_d;
   logic [width-1:0]   tx_sh, tx_sh_d;
   logic [width-1:0]   rx_sh, rx_sh_d;
   logic [width-1:0]   rx_data_d;
   logic               busy_d, done_d, sclk_d, cs_n_d, mosi_d;
   logic               phase_end;
   logic               hold_end;

   assign phase_end = (phase == PW'(clkdiv - 1));
   // HOLD spans the trailing sclk-low half-period plus the cs_n hold half-period
   assign hold_end  = (phase == PW'(2 * clkdiv - 1));

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         phase   <= '0;
         bit_cnt <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         rxData  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         mosi    <= 1'b0;
      end else begin
         state   <= state_d;
         phase   <= phase_d;
         bit_cnt <= bit_cnt_d;
         tx_sh   <= tx_sh_d;
         rx_sh   <= rx_sh_d;
         rxData  <= rx_data_d;
         busy    <= busy_d;
         done    <= done_d;
         sclk    <= sclk_d;
         cs_n    <= cs_n_d;
         mosi    <= mosi_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      phase_d   = phase;
      bit_cnt_d = bit_cnt;
      tx_sh_d   = tx_sh;
      rx_sh_d   = rx_sh;
      rx_data_d = rxData;
      busy_d    = busy;
      done_d    = 1'b0;
      sclk_d    = sclk;
      cs_n_d    = cs_n;
      mosi_d    = mosi;

      case (state)
         IDLE: begin
            if (start) begin
               tx_sh_d   = txData;
               mosi_d    = txData[width-1];
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               phase_d   = '0;
               bit_cnt_d = '0;
               state_d   = SETUP;
            end
         end
         SETUP, SCLK_LOW: begin
            if (phase_end) begin
               phase_d = '0;
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh[width-2:0], miso};
               state_d = SCLK_HIGH;
            end else begin
               phase_d = phase + PW'(1);
            end
         end
         SCLK_HIGH: begin
            if (phase_end) begin
               phase_d = '0;
               sclk_d  = 1'b0;
               if (bit_cnt == BW'(width - 1)) begin
                  state_d = HOLD;
               end else begin
                  tx_sh_d   = tx_sh << 1;
                  mosi_d    = tx_sh[width-2];
                  bit_cnt_d = bit_cnt + BW'(1);
                  state_d   = SCLK_LOW;
               end
            end else begin
               phase_d = phase + PW'(1);
            end
         end
         HOLD: begin
            if (hold_end) begin
               phase_d   = '0;
               cs_n_d    = 1'b1;
               busy_d    = 1'b0;
               mosi_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh;
               state_d   = IDLE;
            end else begin
               phase_d = phase + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
